// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder: opcodes, status codes,
// command/response field positions, FSM state type and the status decoder.
package spi_cmd_pkg;

   // Opcodes carried in the top nibble of the command word
   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_WRITE = 4'h1;
   localparam logic [3:0] OP_READ  = 4'h2;

   // Status codes returned in the response word
   localparam logic [3:0] ST_OK      = 4'd0;
   localparam logic [3:0] ST_BADOP   = 4'd1;
   localparam logic [3:0] ST_RSVD    = 4'd2;
   localparam logic [3:0] ST_LEN     = 4'd3;
   localparam logic [3:0] ST_BADADDR = 4'd4;

   // Frame geometry
   localparam int         CMD_W       = 32;
   localparam logic [5:0] FRAME_BITS  = 6'd32;
   localparam logic [5:0] BIT_CNT_MAX = 6'd63;

   // Command word field positions
   localparam int OP_MSB   = 31;
   localparam int OP_LSB   = 28;
   localparam int ADDR_MSB = 27;
   localparam int ADDR_LSB = 24;
   localparam int RSVD_MSB = 23;
   localparam int RSVD_LSB = 16;
   localparam int DATA_MSB = 15;
   localparam int DATA_LSB = 0;

   // Response word field positions
   localparam int RESP_ECHO_MSB = 31;
   localparam int RESP_ECHO_LSB = 24;
   localparam int RESP_ST_MSB   = 23;
   localparam int RESP_ST_LSB   = 20;
   localparam int RESP_FCNT_MSB = 19;
   localparam int RESP_FCNT_LSB = 16;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RX     = 2'd1,
      S_DECODE = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      return (op == OP_NOP) || (op == OP_WRITE) || (op == OP_READ);
   endfunction

   // Status of a captured frame; the checks are ordered by priority.
   function automatic logic [3:0] cmd_status(input logic [CMD_W-1:0] cmd,
                                             input logic [5:0]       bits,
                                             input logic [4:0]       num_regs);
      logic [3:0] op;
      logic [4:0] addr;
      op   = cmd[OP_MSB:OP_LSB];
      addr = {1'b0, cmd[ADDR_MSB:ADDR_LSB]};
      if (bits != FRAME_BITS)
         return ST_LEN;
      if (!is_legal_op(op))
         return ST_BADOP;
      if (((op == OP_WRITE) || (op == OP_READ)) && (addr >= num_regs))
         return ST_BADADDR;
      if (cmd[RSVD_MSB:RSVD_LSB] != '0)
         return ST_RSVD;
      return ST_OK;
   endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Signals exchanged between the SPI shift stage and the command decoder.
// The master side is the shift stage (raw SPI pins plus captured word);
// the slave side is the decoder, which returns the response word and strobe.
interface spi_cmd_decoder_if;
   import spi_cmd_pkg::*;

   logic             ss_n;
   logic             sclk;
   logic [CMD_W-1:0] spi_word;
   logic [CMD_W-1:0] resp_word;
   logic             resp_valid_n;

   modport master (
      output ss_n,
      output sclk,
      output spi_word,
      input  resp_word,
      input  resp_valid_n
   );

   modport slave (
      input  ss_n,
      input  sclk,
      input  spi_word,
      output resp_word,
      output resp_valid_n
   );

endinterface

// File: rtl/spi_cmd_decoder_edge_sync.sv
// Three-flop synchronizer for a raw asynchronous input, with edge outputs
// taken from the two oldest stages so the latency matches the shift stage.
module edge_sync (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_d,
   output logic o_level,
   output logic o_level_ahead,
   output logic o_rise,
   output logic o_fall
);

   logic [2:0] r_sync;

   // Shift the raw input in; during reset every stage follows the pin so
   // releasing reset never manufactures an edge out of stale contents.
   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_sync <= {3{i_d}};
      else
         r_sync <= {r_sync[1:0], i_d};
   end

   // r_sync[2] is the settled level; r_sync[1] is what it becomes next cycle
   assign o_level       = r_sync[2];
   assign o_level_ahead = r_sync[1];
   assign o_rise        = (r_sync[2:1] == 2'b01);
   assign o_fall        = (r_sync[2:1] == 2'b10);

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: detects frame boundaries, decodes the captured
// command word, updates the setpoint bank and returns a response word to
// the shift stage for transmission during the next frame.
module spi_cmd_decoder
   import spi_cmd_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int DATA_W   = 16
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   spi_cmd_decoder_if.slave           io_spi,
   output logic [NUM_REGS*DATA_W-1:0] o_reg_bank,
   output logic                       o_wr_stb,
   output logic [3:0]                 o_wr_addr,
   output logic                       o_resp_lost
);

   // Synchronizer outputs
   logic w_ss_level;
   logic w_ss_ahead;
   logic w_frame_start;
   logic w_frame_end;
   logic w_sclk_level;
   logic w_sclk_ahead;
   logic w_bit_edge;
   logic w_sclk_fall;
   logic w_unused_sclk;

   // Decode of the word presented by the shift stage
   logic [3:0]        w_status;
   logic              w_commit;
   logic [DATA_W-1:0] w_rd_data;
   logic [DATA_W-1:0] w_resp_data;

   // FSM, counters and registered outputs
   state_t            r_state;
   logic [5:0]        r_bit_cnt;
   logic [3:0]        r_frame_cnt;
   logic [CMD_W-1:0]  r_cmd;
   logic [3:0]        r_status;
   logic              r_restart;
   logic              r_wr_stb;
   logic [3:0]        r_wr_addr;
   logic [CMD_W-1:0]  r_resp_word;
   logic              r_resp_valid_n;
   logic              r_resp_lost;
   logic [DATA_W-1:0] r_bank [NUM_REGS];

   edge_sync u_ss_sync (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_d           (io_spi.ss_n),
      .o_level       (w_ss_level),
      .o_level_ahead (w_ss_ahead),
      .o_rise        (w_frame_end),
      .o_fall        (w_frame_start)
   );

   edge_sync u_sclk_sync (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_d           (io_spi.sclk),
      .o_level       (w_sclk_level),
      .o_level_ahead (w_sclk_ahead),
      .o_rise        (w_bit_edge),
      .o_fall        (w_sclk_fall)
   );

   // Only rising sclk edges matter for bit counting
   assign w_unused_sclk = w_sclk_level ^ w_sclk_ahead ^ w_sclk_fall;

   // The word is judged in the cycle frame_end is seen so that the write
   // strobe can be registered and appear exactly in the DECODE cycle.
   assign w_status = cmd_status(io_spi.spi_word, r_bit_cnt, 5'(NUM_REGS));
   assign w_commit = (w_status == ST_OK) &&
                     (io_spi.spi_word[OP_MSB:OP_LSB] == OP_WRITE);

   // Read port of the setpoint bank, addressed by the latched command
   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (r_cmd[ADDR_MSB:ADDR_LSB] == 4'(i))
            w_rd_data = r_bank[i];
      end
   end

   // Data field of the response: only successful WRITE/READ carry data
   always_comb begin
      w_resp_data = '0;
      if (r_status == ST_OK) begin
         case (r_cmd[OP_MSB:OP_LSB])
            OP_WRITE: w_resp_data = r_cmd[DATA_MSB:DATA_LSB];
            OP_READ:  w_resp_data = w_rd_data;
            default:  w_resp_data = '0;
         endcase
      end
   end

   // Setpoint bank; written during DECODE while the write strobe is high
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_bank[i] <= '0;
      end else if (r_wr_stb) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (r_wr_addr == 4'(i))
               r_bank[i] <= r_cmd[DATA_MSB:DATA_LSB];
         end
      end
   end

   // Frame FSM with bit/frame counters and all registered outputs
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state        <= S_IDLE;
         r_bit_cnt      <= '0;
         r_frame_cnt    <= '0;
         r_cmd          <= '0;
         r_status       <= ST_OK;
         r_restart      <= 1'b0;
         r_wr_stb       <= 1'b0;
         r_wr_addr      <= '0;
         r_resp_word    <= '0;
         r_resp_valid_n <= 1'b1;
         r_resp_lost    <= 1'b0;
      end else begin
         r_wr_stb       <= 1'b0;
         r_resp_valid_n <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_frame_start) begin
                  r_bit_cnt <= '0;
                  r_state   <= S_RX;
               end
            end
            S_RX: begin
               if (w_bit_edge && (r_bit_cnt != BIT_CNT_MAX))
                  r_bit_cnt <= r_bit_cnt + 6'd1;
               if (w_frame_end) begin
                  r_cmd     <= io_spi.spi_word;
                  r_status  <= w_status;
                  r_wr_stb  <= w_commit;
                  if (w_commit)
                     r_wr_addr <= io_spi.spi_word[ADDR_MSB:ADDR_LSB];
                  r_restart <= 1'b0;
                  r_state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_resp_word[RESP_ECHO_MSB:RESP_ECHO_LSB] <= r_cmd[OP_MSB:ADDR_LSB];
               r_resp_word[RESP_ST_MSB:RESP_ST_LSB]     <= r_status;
               r_resp_word[RESP_FCNT_MSB:RESP_FCNT_LSB] <= r_frame_cnt;
               r_resp_word[DATA_MSB:DATA_LSB]           <= w_resp_data;
               // ss_ahead is the synchronized level the RESP cycle will see,
               // so the strobe lands in RESP yet stays a registered output.
               r_resp_valid_n <= ~w_ss_ahead;
               if (w_frame_start) begin
                  r_restart <= 1'b1;
                  r_bit_cnt <= '0;
               end
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (!w_ss_level)
                  r_resp_lost <= 1'b1;
               r_frame_cnt <= r_frame_cnt + 4'd1;
               r_restart   <= 1'b0;
               if (w_frame_start)
                  r_bit_cnt <= '0;
               if (r_restart || w_frame_start)
                  r_state <= S_RX;
               else
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Flatten the bank onto the output bus, register i at [16*i+15:16*i]
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign o_reg_bank[gi*DATA_W +: DATA_W] = r_bank[gi];
   end

   assign io_spi.resp_word    = r_resp_word;
   assign io_spi.resp_valid_n = r_resp_valid_n;
   assign o_wr_stb            = r_wr_stb;
   assign o_wr_addr           = r_wr_addr;
   assign o_resp_lost         = r_resp_lost;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: a behavioural model pushes the
// expected response of every frame onto a queue, and each test task pops
// it once the DUT has had time to respond.
module tb_spi_cmd_decoder;
   import spi_cmd_pkg::*;

   localparam int NUM_REGS = 8;

   typedef struct packed {
      logic [31:0] resp;
      logic        wr;
      logic [3:0]  addr;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NUM_REGS*16-1:0] reg_bank;
   logic                   wr_stb;
   logic [3:0]             wr_addr;
   logic                   resp_lost;

   spi_cmd_decoder_if spi_if ();

   spi_cmd_decoder #(.NUM_REGS(NUM_REGS), .DATA_W(16)) dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .io_spi      (spi_if),
      .o_reg_bank  (reg_bank),
      .o_wr_stb    (wr_stb),
      .o_wr_addr   (wr_addr),
      .o_resp_lost (resp_lost)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Monitor, sampled on the falling edge
   int          mon_resp_n = 0;
   int          mon_wr_n   = 0;
   int          mon_resp_cyc = 0;
   int          mon_wr_cyc   = 0;
   logic [31:0] mon_resp_word = '0;
   logic [3:0]  mon_wr_addr   = '0;
   always @(negedge clk) begin
      if (!spi_if.resp_valid_n) begin
         mon_resp_n++;
         mon_resp_cyc  = cyc;
         mon_resp_word = spi_if.resp_word;
      end
      if (wr_stb) begin
         mon_wr_n++;
         mon_wr_cyc  = cyc;
         mon_wr_addr = wr_addr;
      end
   end

   // Model and scoreboard
   exp_t        sb_q[$];
   logic [15:0] m_bank [NUM_REGS];
   logic [3:0]  m_fcnt = '0;
   int          errors = 0;
   int          checks = 0;

   task automatic model_reset();
      for (int i = 0; i < NUM_REGS; i++) m_bank[i] = '0;
      m_fcnt = '0;
      sb_q.delete();
   endtask

   task automatic model_push(input logic [31:0] word, input int nbits);
      exp_t       e;
      logic [3:0] op, addr, st;
      logic [15:0] data;
      op   = word[31:28];
      addr = word[27:24];
      if (nbits != 32)                                  st = 4'd3;
      else if (op > 4'h2)                               st = 4'd1;
      else if (op != 4'h0 && int'(addr) >= NUM_REGS)    st = 4'd4;
      else if (word[23:16] != 8'h00)                    st = 4'd2;
      else                                              st = 4'd0;
      data = 16'h0;
      if (st == 4'd0 && op == 4'h2) data = m_bank[addr];
      if (st == 4'd0 && op == 4'h1) begin
         data = word[15:0];
         m_bank[addr] = word[15:0];
      end
      e.resp = {word[31:24], st, m_fcnt, data};
      e.wr   = (st == 4'd0 && op == 4'h1);
      e.addr = addr;
      m_fcnt = m_fcnt + 4'd1;
      sb_q.push_back(e);
   endtask

   function automatic logic [NUM_REGS*16-1:0] model_flat();
      logic [NUM_REGS*16-1:0] v;
      for (int i = 0; i < NUM_REGS; i++) v[i*16 +: 16] = m_bank[i];
      return v;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one SPI frame the way the shift stage would present it, then
   // report what the monitor saw; offsets are clocks after the ss_n rise.
   task automatic run_frame(input logic [31:0] word, input int nbits, input bit drop_again,
                            output int n_resp, output int n_wr, output logic [31:0] rword,
                            output logic [3:0] waddr, output int resp_off, output int wr_off);
      int r0, w0, c0;
      r0 = mon_resp_n;
      w0 = mon_wr_n;
      spi_if.ss_n = 1'b0;
      tick(4);
      for (int i = 0; i < nbits; i++) begin
         spi_if.sclk = 1'b1; tick(2);
         spi_if.sclk = 1'b0; tick(2);
      end
      tick(2);
      spi_if.spi_word = word;
      spi_if.ss_n     = 1'b1;
      c0 = cyc;
      if (drop_again) begin
         tick(1);
         spi_if.ss_n = 1'b0;
      end
      tick(10);
      n_resp   = mon_resp_n - r0;
      n_wr     = mon_wr_n - w0;
      rword    = mon_resp_word;
      waddr    = mon_wr_addr;
      resp_off = mon_resp_cyc - c0;
      wr_off   = mon_wr_cyc - c0;
      $display("frame word=%h bits=%0d strobes=%0d resp=%h writes=%0d wr_addr=%0d",
               word, nbits, n_resp, rword, n_wr, waddr);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      checks++; if (spi_if.resp_word !== 32'h0) begin errors++; $display("FAIL reset_resp_word got=%h want=0", spi_if.resp_word); end
      checks++; if (spi_if.resp_valid_n !== 1'b1) begin errors++; $display("FAIL reset_resp_valid_n got=%b want=1", spi_if.resp_valid_n); end
      checks++; if (reg_bank !== '0) begin errors++; $display("FAIL reset_reg_bank got=%h want=0", reg_bank); end
      checks++; if (wr_stb !== 1'b0 || wr_addr !== 4'd0) begin errors++; $display("FAIL reset_wr got=%b/%0d want=0/0", wr_stb, wr_addr); end
      checks++; if (resp_lost !== 1'b0) begin errors++; $display("FAIL reset_resp_lost got=%b want=0", resp_lost); end
      rst = 1'b0;
      tick(3);
   endtask

   task automatic test_write();
      exp_t e; int nr, nw, ro, wo; logic [31:0] rw; logic [3:0] wa;
      model_push(32'h1300_ABCD, 32);
      run_frame(32'h1300_ABCD, 32, 1'b0, nr, nw, rw, wa, ro, wo);
      e = sb_q.pop_front();
      checks++; if (nw !== 1) begin errors++; $display("FAIL write_stb_count got=%0d want=1", nw); end
      checks++; if (wa !== 4'd3) begin errors++; $display("FAIL write_addr got=%0d want=3", wa); end
      checks++; if (wo !== 3) begin errors++; $display("FAIL write_latency got=%0d want=3", wo); end
      checks++; if (nr !== 1) begin errors++; $display("FAIL write_resp_strobes got=%0d want=1", nr); end
      checks++; if (ro !== 4) begin errors++; $display("FAIL write_resp_latency got=%0d want=4", ro); end
      checks++; if (rw !== 32'h1300_ABCD || rw !== e.resp) begin errors++; $display("FAIL write_resp_word got=%h want=%h", rw, e.resp); end
      checks++; if (reg_bank[3*16 +: 16] !== 16'hABCD) begin errors++; $display("FAIL write_bank3 got=%h want=abcd", reg_bank[3*16 +: 16]); end
   endtask

   task automatic test_read();
      exp_t e; int nr, nw, ro, wo; logic [31:0] rw; logic [3:0] wa;
      model_push(32'h2300_0000, 32);
      run_frame(32'h2300_0000, 32, 1'b0, nr, nw, rw, wa, ro, wo);
      e = sb_q.pop_front();
      checks++; if (nw !== 0) begin errors++; $display("FAIL read_no_write got=%0d want=0", nw); end
      checks++; if (nr !== 1) begin errors++; $display("FAIL read_resp_strobes got=%0d want=1", nr); end
      checks++; if (rw !== 32'h2301_ABCD || rw !== e.resp) begin errors++; $display("FAIL read_resp_word got=%h want=%h", rw, e.resp); end
      checks++; if (spi_if.resp_word !== e.resp) begin errors++; $display("FAIL read_resp_hold got=%h want=%h", spi_if.resp_word, e.resp); end
   endtask

   task automatic test_bad_addr();
      exp_t e; int nr, nw, ro, wo; logic [31:0] rw; logic [3:0] wa;
      model_push(32'h1900_1111, 32);
      run_frame(32'h1900_1111, 32, 1'b0, nr, nw, rw, wa, ro, wo);
      e = sb_q.pop_front();
      checks++; if (nw !== 0) begin errors++; $display("FAIL badaddr_no_write got=%0d want=0", nw); end
      checks++; if (rw[23:16] !== 8'h42 || rw !== e.resp) begin errors++; $display("FAIL badaddr_resp got=%h want=%h", rw, e.resp); end
      checks++; if (reg_bank !== model_flat()) begin errors++; $display("FAIL badaddr_bank got=%h want=%h", reg_bank, model_flat()); end
   endtask

   task automatic test_short();
      exp_t e; int nr, nw, ro, wo; logic [31:0] rw; logic [3:0] wa;
      model_push(32'h1300_5555, 31);
      run_frame(32'h1300_5555, 31, 1'b0, nr, nw, rw, wa, ro, wo);
      e = sb_q.pop_front();
      checks++; if (nw !== 0) begin errors++; $display("FAIL short_no_write got=%0d want=0", nw); end
      checks++; if (nr !== 1 || rw !== 32'h1333_0000 || rw !== e.resp) begin errors++; $display("FAIL short_resp got=%0d/%h want=1/%h", nr, rw, e.resp); end
      checks++; if (reg_bank[3*16 +: 16] !== 16'hABCD) begin errors++; $display("FAIL short_bank3 got=%h want=abcd", reg_bank[3*16 +: 16]); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [11];
      int          bits  [11];
      exp_t e; int nr, nw, ro, wo; logic [31:0] rw; logic [3:0] wa;
      words = '{32'h1500_1234, 32'h3000_0000, 32'h1201_0000, 32'h0000_0000, 32'hF900_0000,
                32'h1901_0000, 32'h2500_0000, 32'h1700_FFFF, 32'h2800_0000, 32'h2700_0000,
                32'h1300_0001};
      bits  = '{32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 33};
      for (int i = 0; i < 11; i++) begin
         model_push(words[i], bits[i]);
         run_frame(words[i], bits[i], 1'b0, nr, nw, rw, wa, ro, wo);
         e = sb_q.pop_front();
         checks++; if (nr !== 1 || ro !== 4 || rw !== e.resp) begin errors++; $display("FAIL seq%0d_resp got=%0d@%0d/%h want=1@4/%h", i, nr, ro, rw, e.resp); end
         checks++; if (nw !== int'(e.wr)) begin errors++; $display("FAIL seq%0d_wr_count got=%0d want=%0d", i, nw, e.wr); end
         if (e.wr) begin
            checks++; if (wa !== e.addr || wo !== 3) begin errors++; $display("FAIL seq%0d_wr got=%0d@%0d want=%0d@3", i, wa, wo, e.addr); end
         end
         checks++; if (reg_bank !== model_flat()) begin errors++; $display("FAIL seq%0d_bank got=%h want=%h", i, reg_bank, model_flat()); end
      end
   endtask

   task automatic test_resp_lost();
      exp_t e; int nr, nw, ro, wo; logic [31:0] rw; logic [3:0] wa;
      model_push(32'h2300_0000, 32);
      run_frame(32'h2300_0000, 32, 1'b1, nr, nw, rw, wa, ro, wo);
      e = sb_q.pop_front();
      checks++; if (nr !== 0) begin errors++; $display("FAIL lost_strobe got=%0d want=0", nr); end
      checks++; if (resp_lost !== 1'b1) begin errors++; $display("FAIL lost_flag got=%b want=1", resp_lost); end
      checks++; if (spi_if.resp_word !== e.resp) begin errors++; $display("FAIL lost_resp_word got=%h want=%h", spi_if.resp_word, e.resp); end
      model_push(32'h1600_0BAD, 32);
      run_frame(32'h1600_0BAD, 32, 1'b0, nr, nw, rw, wa, ro, wo);
      e = sb_q.pop_front();
      checks++; if (nr !== 1 || rw !== e.resp) begin errors++; $display("FAIL lost_next_resp got=%0d/%h want=1/%h", nr, rw, e.resp); end
      checks++; if (nw !== 1 || wa !== 4'd6) begin errors++; $display("FAIL lost_next_wr got=%0d/%0d want=1/6", nw, wa); end
      checks++; if (resp_lost !== 1'b1) begin errors++; $display("FAIL lost_sticky got=%b want=1", resp_lost); end
   endtask

   task automatic test_reset_mid_frame();
      exp_t e; int nr, nw, ro, wo, r0, w0; logic [31:0] rw; logic [3:0] wa;
      r0 = mon_resp_n;
      w0 = mon_wr_n;
      spi_if.ss_n = 1'b0;
      tick(4);
      for (int i = 0; i < 16; i++) begin
         spi_if.sclk = 1'b1; tick(2);
         spi_if.sclk = 1'b0; tick(2);
      end
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      spi_if.spi_word = 32'h1400_7777;
      tick(2);
      spi_if.ss_n = 1'b1;
      tick(10);
      model_reset();
      $display("reset mid-frame strobes=%0d writes=%0d", mon_resp_n - r0, mon_wr_n - w0);
      checks++; if (mon_resp_n - r0 !== 0 || mon_wr_n - w0 !== 0) begin errors++; $display("FAIL midrst_activity got=%0d/%0d want=0/0", mon_resp_n - r0, mon_wr_n - w0); end
      checks++; if (spi_if.resp_word !== 32'h0 || spi_if.resp_valid_n !== 1'b1) begin errors++; $display("FAIL midrst_resp got=%h/%b want=0/1", spi_if.resp_word, spi_if.resp_valid_n); end
      checks++; if (reg_bank !== '0 || wr_addr !== 4'd0 || resp_lost !== 1'b0) begin errors++; $display("FAIL midrst_outputs got=%h/%0d/%b want=0/0/0", reg_bank, wr_addr, resp_lost); end
      model_push(32'h1300_ABCD, 32);
      run_frame(32'h1300_ABCD, 32, 1'b0, nr, nw, rw, wa, ro, wo);
      e = sb_q.pop_front();
      checks++; if (nr !== 1 || rw !== 32'h1300_ABCD || rw !== e.resp) begin errors++; $display("FAIL midrst_next_resp got=%0d/%h want=1/%h", nr, rw, e.resp); end
      checks++; if (nw !== 1 || wa !== 4'd3 || reg_bank !== model_flat()) begin errors++; $display("FAIL midrst_next_wr got=%0d/%0d want=1/3", nw, wa); end
   endtask

   initial begin
      spi_if.ss_n     = 1'b1;
      spi_if.sclk     = 1'b0;
      spi_if.spi_word = '0;
      model_reset();
      test_reset();
      test_write();
      test_read();
      test_bad_addr();
      test_short();
      test_back_to_back();
      test_resp_lost();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
